// File: rtl/scoreboard_reg_file_if.sv
// Writeback, read and issue signals of the scoreboarded register file.
// The master is the pipeline; the slave is the register file.
interface scoreboard_reg_file_if #(
  parameter int BIT_WIDTH       = 32,
  parameter int REG_INDEX_WIDTH = 4
);
  logic                       en_write;
  logic [REG_INDEX_WIDTH-1:0] dr_ind;
  logic [BIT_WIDTH-1:0]       data_in;
  logic [REG_INDEX_WIDTH-1:0] sr1_ind;
  logic [REG_INDEX_WIDTH-1:0] sr2_ind;
  logic [BIT_WIDTH-1:0]       sr1;
  logic [BIT_WIDTH-1:0]       sr2;
  logic                       sr1_busy;
  logic                       sr2_busy;
  logic                       issue_valid;
  logic [REG_INDEX_WIDTH-1:0] issue_ind;
  logic                       issue_ready;
  logic [REG_INDEX_WIDTH:0]   busy_count;

  modport master (
    output en_write, dr_ind, data_in, sr1_ind, sr2_ind, issue_valid, issue_ind,
    input  sr1, sr2, sr1_busy, sr2_busy, issue_ready, busy_count
  );

  modport slave (
    input  en_write, dr_ind, data_in, sr1_ind, sr2_ind, issue_valid, issue_ind,
    output sr1, sr2, sr1_busy, sr2_busy, issue_ready, busy_count
  );
endinterface

// File: rtl/scoreboard_reg_file.sv
// Register file with a per-register busy scoreboard, optional write-through
// forwarding and an optional hard-wired zero register.

module sb_rd_port #(
  parameter int BIT_WIDTH       = 32,
  parameter int REG_INDEX_WIDTH = 4,
  parameter bit ZERO_REG        = 1'b1,
  parameter bit BYPASS          = 1'b1
) (
  input  logic [REG_INDEX_WIDTH-1:0]                          ind,
  input  logic [(1<<REG_INDEX_WIDTH)-1:0][BIT_WIDTH-1:0]      regs,
  input  logic [(1<<REG_INDEX_WIDTH)-1:0]                     busy,
  input  logic                                                wr_ok,
  input  logic [REG_INDEX_WIDTH-1:0]                          dr_ind,
  input  logic [BIT_WIDTH-1:0]                                data_in,
  output logic [BIT_WIDTH-1:0]                                data,
  output logic                                                data_busy
);
  logic zero, fwd;

  // wr_ok already excludes a zeroed r0, so fwd never fires for it
  assign zero = ZERO_REG && (ind == '0);
  assign fwd  = BYPASS && wr_ok && (dr_ind == ind);

  always_comb begin
    data      = regs[ind];
    data_busy = busy[ind];
    if (zero) begin
      data      = '0;
      data_busy = 1'b0;
    end else if (fwd) begin
      data      = data_in;
      data_busy = 1'b0;
    end
  end
endmodule

module scoreboard_reg_file #(
  parameter int                   BIT_WIDTH       = 32,
  parameter int                   REG_INDEX_WIDTH = 4,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE     = '0,
  parameter bit                   ZERO_REG        = 1'b1,
  parameter bit                   BYPASS          = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  scoreboard_reg_file_if.slave bus
);
  localparam int DEPTH = 1 << REG_INDEX_WIDTH;
  localparam int NUM_RD = 2;

  logic [DEPTH-1:0][BIT_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                busy, busy_nxt, set_vec, clr_vec;
  logic [REG_INDEX_WIDTH:0]        cnt;
  logic                            wr_ok, issue_zero, issue_fire, inc, dec;

  logic [NUM_RD-1:0][REG_INDEX_WIDTH-1:0] rd_ind;
  logic [NUM_RD-1:0][BIT_WIDTH-1:0]       rd_data;
  logic [NUM_RD-1:0]                      rd_busy;

  assign wr_ok      = bus.en_write && !(ZERO_REG && (bus.dr_ind == '0));
  assign issue_zero = ZERO_REG && (bus.issue_ind == '0);

  assign bus.issue_ready = issue_zero || !busy[bus.issue_ind] ||
                           (bus.en_write && (bus.dr_ind == bus.issue_ind));
  assign issue_fire = bus.issue_valid && bus.issue_ready && !issue_zero;

  assign set_vec  = issue_fire ? (DEPTH'(1) << bus.issue_ind) : '0;
  assign clr_vec  = wr_ok ? (DEPTH'(1) << bus.dr_ind) : '0;
  // set after clear: a same-index issue keeps the register reserved
  assign busy_nxt = (busy & ~clr_vec) | set_vec;

  // count only real bit transitions so cnt tracks popcount(busy) exactly
  assign inc = issue_fire && !busy[bus.issue_ind];
  assign dec = wr_ok && busy[bus.dr_ind] &&
               !(issue_fire && (bus.issue_ind == bus.dr_ind));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VALUE;
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_ok) regs[bus.dr_ind] <= bus.data_in;
      busy <= busy_nxt;
      case ({inc, dec})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.busy_count = cnt;

  assign rd_ind = {bus.sr2_ind, bus.sr1_ind};

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    sb_rd_port #(
      .BIT_WIDTH       (BIT_WIDTH),
      .REG_INDEX_WIDTH (REG_INDEX_WIDTH),
      .ZERO_REG        (ZERO_REG),
      .BYPASS          (BYPASS)
    ) u_rd (
      .ind       (rd_ind[p]),
      .regs      (regs),
      .busy      (busy),
      .wr_ok     (wr_ok),
      .dr_ind    (bus.dr_ind),
      .data_in   (bus.data_in),
      .data      (rd_data[p]),
      .data_busy (rd_busy[p])
    );
  end

  assign bus.sr1      = rd_data[0];
  assign bus.sr2      = rd_data[1];
  assign bus.sr1_busy = rd_busy[0];
  assign bus.sr2_busy = rd_busy[1];
endmodule

// File: tb/tb_scoreboard_reg_file.sv
// Directed bench: a forwarding instance (u_dut) and a non-forwarding
// instance (u_nob) share the same stimulus.
module tb_scoreboard_reg_file;
  localparam int BW  = 32;
  localparam int IW  = 4;
  localparam logic [BW-1:0] RV = 32'h0000_00A5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  scoreboard_reg_file_if #(.BIT_WIDTH(BW), .REG_INDEX_WIDTH(IW)) b0 ();
  scoreboard_reg_file_if #(.BIT_WIDTH(BW), .REG_INDEX_WIDTH(IW)) b1 ();

  assign b1.en_write    = b0.en_write;
  assign b1.dr_ind      = b0.dr_ind;
  assign b1.data_in     = b0.data_in;
  assign b1.sr1_ind     = b0.sr1_ind;
  assign b1.sr2_ind     = b0.sr2_ind;
  assign b1.issue_valid = b0.issue_valid;
  assign b1.issue_ind   = b0.issue_ind;

  scoreboard_reg_file #(.BIT_WIDTH(BW), .REG_INDEX_WIDTH(IW), .RESET_VALUE(RV),
                        .ZERO_REG(1'b1), .BYPASS(1'b1))
    u_dut (.clk(clk), .reset(reset), .bus(b0));

  scoreboard_reg_file #(.BIT_WIDTH(BW), .REG_INDEX_WIDTH(IW), .RESET_VALUE(RV),
                        .ZERO_REG(1'b1), .BYPASS(1'b0))
    u_nob (.clk(clk), .reset(reset), .bus(b1));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance past the next rising edge; inputs then change away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.en_write    = 1'b0;
    b0.issue_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    b0.en_write    = 1'b0;
    b0.dr_ind      = '0;
    b0.data_in     = '0;
    b0.sr1_ind     = 4'd3;
    b0.sr2_ind     = 4'd0;
    b0.issue_valid = 1'b0;
    b0.issue_ind   = 4'd5;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_sr1",      b0.sr1, RV);
    chk("rst_sr2_r0",   b0.sr2, 0);
    chk("rst_busy_cnt", b0.busy_count, 0);
    chk("rst_ready",    b0.issue_ready, 1);
    chk("rst_sr1_busy", b0.sr1_busy, 0);

    // write r5 with same-cycle forwarding, then read back
    b0.en_write = 1'b1; b0.dr_ind = 4'd5; b0.data_in = 32'hDEADBEEF; b0.sr1_ind = 4'd5;
    #1;
    chk("fwd_sr1_r5", b0.sr1, 32'hDEADBEEF);
    tick(); idle(); #1;
    chk("rd_r5",      b0.sr1, 32'hDEADBEEF);
    chk("rd_r5_busy", b0.sr1_busy, 0);

    // forwarding vs no forwarding on r3
    b0.en_write = 1'b1; b0.dr_ind = 4'd3; b0.data_in = 32'h12345678; b0.sr2_ind = 4'd3;
    #1;
    chk("byp_sr2",   b0.sr2, 32'h12345678);
    chk("nobyp_sr2", b1.sr2, RV);
    tick(); idle(); #1;
    chk("nobyp_sr2_after", b1.sr2, 32'h12345678);

    // reserve r7, then release it by writeback
    b0.issue_valid = 1'b1; b0.issue_ind = 4'd7; b0.sr1_ind = 4'd7;
    #1;
    chk("iss7_ready", b0.issue_ready, 1);
    tick(); idle(); #1;
    chk("iss7_cnt",      b0.busy_count, 1);
    chk("iss7_notready", b0.issue_ready, 0);
    chk("iss7_sr1_busy", b0.sr1_busy, 1);
    chk("iss7_nob_busy", b1.sr1_busy, 1);
    b0.en_write = 1'b1; b0.dr_ind = 4'd7; b0.data_in = 32'h77;
    #1;
    chk("wb7_fwd_busy",  b0.sr1_busy, 0);
    chk("wb7_nob_busy",  b1.sr1_busy, 1);
    chk("wb7_ready",     b0.issue_ready, 1);
    tick(); idle(); #1;
    chk("wb7_cnt",       b0.busy_count, 0);
    chk("wb7_sr1_busy",  b0.sr1_busy, 0);
    chk("wb7_sr1",       b0.sr1, 32'h77);

    // same-cycle release and re-reserve of r7
    b0.issue_valid = 1'b1; b0.issue_ind = 4'd7;
    tick(); idle(); #1;
    chk("re7_cnt", b0.busy_count, 1);
    b0.en_write = 1'b1; b0.dr_ind = 4'd7; b0.data_in = 32'h88;
    b0.issue_valid = 1'b1; b0.issue_ind = 4'd7;
    #1;
    chk("re7_ready", b0.issue_ready, 1);
    tick(); idle(); #1;
    chk("re7_cnt_hold", b0.busy_count, 1);
    chk("re7_busy",     b0.sr1_busy, 1);
    chk("re7_data",     b0.sr1, 32'h88);
    b0.en_write = 1'b1; b0.dr_ind = 4'd7; b0.data_in = 32'h99;
    tick(); idle(); #1;
    chk("re7_clr_cnt", b0.busy_count, 0);

    // zero register ignores writes and reservations
    b0.en_write = 1'b1; b0.dr_ind = 4'd0; b0.data_in = 32'hFFFFFFFF;
    b0.issue_valid = 1'b1; b0.issue_ind = 4'd0; b0.sr1_ind = 4'd0;
    #1;
    chk("r0_fwd_sr1", b0.sr1, 0);
    chk("r0_ready",   b0.issue_ready, 1);
    chk("r0_busy",    b0.sr1_busy, 0);
    tick(); idle(); #1;
    chk("r0_sr1", b0.sr1, 0);
    chk("r0_cnt", b0.busy_count, 0);

    // writeback to a non-busy register leaves the count alone
    b0.en_write = 1'b1; b0.dr_ind = 4'd9; b0.data_in = 32'h9;
    tick(); idle(); #1;
    chk("wb_nonbusy_cnt", b0.busy_count, 0);

    // reserve r1, r2, r4, then swap r2 for r6 in one cycle
    b0.issue_valid = 1'b1; b0.issue_ind = 4'd1; tick();
    b0.issue_ind = 4'd2; tick();
    b0.issue_ind = 4'd4; tick();
    idle(); #1;
    chk("three_cnt", b0.busy_count, 3);
    b0.issue_valid = 1'b1; b0.issue_ind = 4'd6;
    b0.en_write = 1'b1; b0.dr_ind = 4'd2; b0.data_in = 32'h22;
    tick(); idle();
    b0.sr1_ind = 4'd2; b0.sr2_ind = 4'd6; #1;
    chk("swap_cnt",   b0.busy_count, 3);
    chk("swap_r2",    b0.sr1_busy, 0);
    chk("swap_r6",    b0.sr2_busy, 1);

    // reset beats a same-cycle writeback and issue
    reset = 1'b1;
    b0.en_write = 1'b1; b0.dr_ind = 4'd1; b0.data_in = 32'h1111;
    b0.issue_valid = 1'b1; b0.issue_ind = 4'd9;
    tick(); idle(); reset = 1'b0;
    b0.sr1_ind = 4'd1; b0.sr2_ind = 4'd9; b0.issue_ind = 4'd4; #1;
    chk("rst2_cnt",   b0.busy_count, 0);
    chk("rst2_r1",    b0.sr1, RV);
    chk("rst2_r1_bz", b0.sr1_busy, 0);
    chk("rst2_r9_bz", b0.sr2_busy, 0);
    chk("rst2_ready", b0.issue_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
